// File: rtl/prio_capture_fifo.sv
// prio_capture_fifo: arbitrated multi-channel sample capture into a
// circular buffer, drained on a valid/ready port, with overflow tracking.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid[NCH]         per-channel sample request
//   in_data[NCH*WIDTH]    channel i at bits [i*WIDTH +: WIDTH]
//   in_grant[NCH]         comb. one-hot (or zero) grant for this cycle
//   out_valid/out_ready   head handshake; pop on both high
//   out_data, out_ch      head sample and its source channel (0 if empty)
//   count, full           occupancy 0..DEPTH and count == DEPTH
//   overflow, drop_cnt    sticky drop flag, saturating dropped-cycle count
//   clr_ovf               clears overflow and drop_cnt (a drop wins)
module prio_capture_fifo #(
   parameter int WIDTH = 8,
   parameter int NCH   = 3,
   parameter int DEPTH = 1024,
   parameter int RR_EN = 0,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_grant,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CW-1:0]        out_ch,
   output logic [AW:0]          count,
   output logic                 full,
   output logic                 overflow,
   output logic [15:0]          drop_cnt,
   input  logic                 clr_ovf
);

   localparam int              EW      = CW + WIDTH;
   localparam logic [CW:0]     NCH_W   = (CW+1)'(NCH);
   localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 1);
   localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);

   // Buffer storage; entries are {channel, sample}. Not reset.
   logic [EW-1:0]    mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;

   logic             full_w;
   logic             empty_w;
   logic             push_w;
   logic             pop_w;
   logic             drop_w;
   logic             found_w;
   logic [CW-1:0]    win_w;
   logic [CW-1:0]    base_w;
   logic [EW-1:0]    head_w;
   logic [WIDTH-1:0] chan_data [NCH];

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         chan_data[k] = in_data[k*WIDTH +: WIDTH];
      end
   end

   assign full_w  = (count_q == DEPTH_W);
   assign empty_w = (count_q == '0);

   // Fixed priority is a round-robin search that always starts at 0.
   assign base_w = (RR_EN != 0) ? rr_ptr_q : '0;

   always_comb begin
      logic [CW:0] idx;
      found_w = 1'b0;
      win_w   = '0;
      idx     = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = {1'b0, base_w} + (CW+1)'(k);
         if (idx >= NCH_W) begin
            idx = idx - NCH_W;
         end
         if (!found_w && in_valid[idx[CW-1:0]]) begin
            found_w = 1'b1;
            win_w   = idx[CW-1:0];
         end
      end
   end

   // No pass-through: a full buffer refuses writes even while popping.
   assign push_w = found_w && !full_w;
   assign pop_w  = !empty_w && out_ready;
   assign drop_w = full_w && (|in_valid);

   always_comb begin
      in_grant = '0;
      if (push_w) begin
         in_grant[win_w] = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rr_ptr_d   = rr_ptr_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (push_w) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         rr_ptr_d = (win_w == LAST_CH) ? '0 : win_w + CW'(1);
      end

      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push_w, pop_w})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      // Clear first so a same-cycle drop restarts the count at 1.
      if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
      if (drop_w) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_d + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rr_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rr_ptr_q   <= rr_ptr_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_w) begin
         mem[wr_ptr_q] <= {win_w, chan_data[win_w]};
      end
   end

   assign head_w    = mem[rd_ptr_q];
   assign out_valid = !empty_w;
   assign out_data  = empty_w ? '0 : head_w[WIDTH-1:0];
   assign out_ch    = empty_w ? '0 : head_w[EW-1:WIDTH];
   assign count     = count_q;
   assign full      = full_w;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_prio_capture_fifo.sv
// Bench for prio_capture_fifo: a fixed-priority and a round-robin
// instance share stimulus and are checked against a queue-based model.
module tb_prio_capture_fifo;

   localparam int W  = 8;
   localparam int N  = 3;
   localparam int D  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic           out_ready;
   logic           clr_ovf;

   logic [N-1:0] gr0, gr1;
   logic         vld0, vld1;
   logic [W-1:0] dat0, dat1;
   logic [1:0]   ch0, ch1;
   logic [2:0]   cnt0, cnt1;
   logic         ful0, ful1;
   logic         ovf0, ovf1;
   logic [15:0]  drp0, drp1;

   prio_capture_fifo #(.WIDTH(W), .NCH(N), .DEPTH(D), .RR_EN(0)) u_fp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_grant(gr0), .out_valid(vld0), .out_ready(out_ready),
      .out_data(dat0), .out_ch(ch0), .count(cnt0), .full(ful0),
      .overflow(ovf0), .drop_cnt(drp0), .clr_ovf(clr_ovf)
   );

   prio_capture_fifo #(.WIDTH(W), .NCH(N), .DEPTH(D), .RR_EN(1)) u_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_grant(gr1), .out_valid(vld1), .out_ready(out_ready),
      .out_data(dat1), .out_ch(ch1), .count(cnt1), .full(ful1),
      .overflow(ovf1), .drop_cnt(drp1), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: entries are (channel << 8) | sample.
   int unsigned mq0[$];
   int unsigned mq1[$];
   int          rr1;
   int          movf [2];
   int          mdrop [2];

   int fp_pop[$];
   int rr_pop[$];
   int rr_gnt[$];

   typedef struct {
      int g; int v; int d; int ch; int cnt; int fl; int ov; int dr;
   } obs_t;

   typedef struct {
      logic [2:0]  v;
      logic [23:0] d;
      logic        rdy;
      logic        clr;
      int eg; int ecnt; int efull; int eovf; int edrop; int edat;
   } vec_t;

   vec_t tbl [19];

   task automatic cmp(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic int msize(input int i);
      return (i == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic int mfront(input int i);
      return (i == 0) ? int'(mq0[0]) : int'(mq1[0]);
   endfunction

   function automatic logic [N-1:0] mgrant(input int i, input logic [N-1:0] v);
      int start;
      logic [N-1:0] one;
      one = 1;
      if (msize(i) == D) return '0;
      start = (i == 1) ? rr1 : 0;
      for (int k = 0; k < N; k++) begin
         if (v[(start + k) % N]) return one << ((start + k) % N);
      end
      return '0;
   endfunction

   function automatic obs_t model_obs(input int i, input logic [N-1:0] v);
      obs_t r;
      int   sz;
      int   f;
      sz    = msize(i);
      f     = (sz > 0) ? mfront(i) : 0;
      r.g   = int'(mgrant(i, v));
      r.v   = (sz > 0) ? 1 : 0;
      r.d   = f & 255;
      r.ch  = f >> 8;
      r.cnt = sz;
      r.fl  = (sz == D) ? 1 : 0;
      r.ov  = movf[i];
      r.dr  = mdrop[i];
      return r;
   endfunction

   function automatic obs_t dut_obs(input int i);
      obs_t r;
      if (i == 0) begin
         r = '{int'(gr0), int'(vld0), int'(dat0), int'(ch0),
               int'(cnt0), int'(ful0), int'(ovf0), int'(drp0)};
      end else begin
         r = '{int'(gr1), int'(vld1), int'(dat1), int'(ch1),
               int'(cnt1), int'(ful1), int'(ovf1), int'(drp1)};
      end
      return r;
   endfunction

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      rr1 = 0;
      for (int i = 0; i < 2; i++) begin
         movf[i]  = 0;
         mdrop[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input logic [N-1:0] g,
                             input logic [N-1:0] v, input logic [N*W-1:0] d,
                             input logic rdy, input logic clr);
      int sz;
      int c;
      int unsigned e;
      sz = msize(i);
      if (sz > 0 && rdy) begin
         if (i == 0) void'(mq0.pop_front());
         else        void'(mq1.pop_front());
      end
      if (g != 0) begin
         c = 0;
         for (int k = 0; k < N; k++) if (g[k]) c = k;
         e = (c << 8) | int'(d[c*W +: W]);
         if (i == 0) mq0.push_back(e);
         else begin
            mq1.push_back(e);
            rr1 = (c + 1) % N;
         end
      end
      if (sz == D && v != 0) begin
         movf[i]  = 1;
         mdrop[i] = clr ? 1 : ((mdrop[i] == 65535) ? 65535 : mdrop[i] + 1);
      end else if (clr) begin
         movf[i]  = 0;
         mdrop[i] = 0;
      end
   endtask

   task automatic cmp_obs(input string tag, input int i);
      obs_t a;
      obs_t e;
      string t;
      a = dut_obs(i);
      e = model_obs(i, in_valid);
      t = $sformatf("%s/u%0d", tag, i);
      cmp({t, " grant"},     a.g,   e.g);
      cmp({t, " out_valid"}, a.v,   e.v);
      cmp({t, " out_data"},  a.d,   e.d);
      cmp({t, " out_ch"},    a.ch,  e.ch);
      cmp({t, " count"},     a.cnt, e.cnt);
      cmp({t, " full"},      a.fl,  e.fl);
      cmp({t, " overflow"},  a.ov,  e.ov);
      cmp({t, " drop_cnt"},  a.dr,  e.dr);
   endtask

   // Called at a falling edge: apply inputs, then check settled outputs.
   task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic rdy, input logic clr, input string tag);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      clr_ovf   = clr;
      #1;
      cmp_obs(tag, 0);
      cmp_obs(tag, 1);
   endtask

   task automatic edge_step();
      logic [N-1:0] g0;
      logic [N-1:0] g1;
      g0 = mgrant(0, in_valid);
      g1 = mgrant(1, in_valid);
      if (vld0 && out_ready) fp_pop.push_back(int'(dat0));
      if (vld1 && out_ready) rr_pop.push_back(int'(ch1));
      rr_gnt.push_back(int'(gr1));
      @(posedge clk);
      model_step(0, g0, in_valid, in_data, out_ready, clr_ovf);
      model_step(1, g1, in_valid, in_data, out_ready, clr_ovf);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N*W-1:0] rd;
      logic           rr;
      int             exp_seq[$];

      tbl[0]  = '{3'b111, 24'h332211, 1'b0, 1'b0, 1, 0, 0, 0, 0, 'h00};
      tbl[1]  = '{3'b000, 24'h332211, 1'b0, 1'b0, 0, 1, 0, 0, 0, 'h11};
      tbl[2]  = '{3'b010, 24'h332211, 1'b0, 1'b0, 2, 1, 0, 0, 0, 'h11};
      tbl[3]  = '{3'b100, 24'h332211, 1'b0, 1'b0, 4, 2, 0, 0, 0, 'h11};
      tbl[4]  = '{3'b011, 24'h332211, 1'b0, 1'b0, 1, 3, 0, 0, 0, 'h11};
      tbl[5]  = '{3'b001, 24'h332211, 1'b0, 1'b0, 0, 4, 1, 0, 0, 'h11};
      tbl[6]  = '{3'b000, 24'h332211, 1'b0, 1'b0, 0, 4, 1, 1, 1, 'h11};
      tbl[7]  = '{3'b111, 24'h332211, 1'b1, 1'b0, 0, 4, 1, 1, 1, 'h11};
      tbl[8]  = '{3'b000, 24'h332211, 1'b0, 1'b0, 0, 3, 0, 1, 2, 'h22};
      tbl[9]  = '{3'b000, 24'h332211, 1'b0, 1'b1, 0, 3, 0, 1, 2, 'h22};
      tbl[10] = '{3'b000, 24'h332211, 1'b0, 1'b0, 0, 3, 0, 0, 0, 'h22};
      tbl[11] = '{3'b001, 24'h332211, 1'b0, 1'b0, 1, 3, 0, 0, 0, 'h22};
      tbl[12] = '{3'b001, 24'h332211, 1'b0, 1'b1, 0, 4, 1, 0, 0, 'h22};
      tbl[13] = '{3'b000, 24'h332211, 1'b0, 1'b1, 0, 4, 1, 1, 1, 'h22};
      tbl[14] = '{3'b000, 24'h332211, 1'b1, 1'b0, 0, 4, 1, 0, 0, 'h22};
      tbl[15] = '{3'b000, 24'h332211, 1'b1, 1'b0, 0, 3, 0, 0, 0, 'h33};
      tbl[16] = '{3'b000, 24'h332211, 1'b1, 1'b0, 0, 2, 0, 0, 0, 'h11};
      tbl[17] = '{3'b000, 24'h332211, 1'b1, 1'b0, 0, 1, 0, 0, 0, 'h11};
      tbl[18] = '{3'b000, 24'h332211, 1'b0, 1'b0, 0, 0, 0, 0, 0, 'h00};

      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      drive('0, '0, 1'b1, 1'b0, "reset");
      edge_step();

      // Directed vectors on the fixed-priority instance.
      for (int r = 0; r < 19; r++) begin
         drive(tbl[r].v, tbl[r].d, tbl[r].rdy, tbl[r].clr, "tbl");
         cmp($sformatf("tbl%0d grant", r),    int'(gr0),  tbl[r].eg);
         cmp($sformatf("tbl%0d count", r),    int'(cnt0), tbl[r].ecnt);
         cmp($sformatf("tbl%0d full", r),     int'(ful0), tbl[r].efull);
         cmp($sformatf("tbl%0d overflow", r), int'(ovf0), tbl[r].eovf);
         cmp($sformatf("tbl%0d drop_cnt", r), int'(drp0), tbl[r].edrop);
         cmp($sformatf("tbl%0d out_data", r), int'(dat0), tbl[r].edat);
         edge_step();
      end

      // Asynchronous reset while holding data and a pending overflow.
      for (int k = 0; k < 5; k++) begin
         drive(3'b001, 24'h0000C0 + 24'(k), 1'b0, 1'b0, "prefill");
         edge_step();
      end
      cmp("pre-reset count", int'(cnt0), 4);
      cmp("pre-reset overflow", int'(ovf0), 1);
      in_valid = '0;
      #2;
      rst = 1'b1;
      #1;
      cmp("async out_valid", int'(vld0), 0);
      cmp("async count", int'(cnt0), 0);
      cmp("async full", int'(ful0), 0);
      cmp("async overflow", int'(ovf0), 0);
      cmp("async drop_cnt", int'(drp0), 0);
      cmp("async rr count", int'(cnt1), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(3'b001, 24'h00005A, 1'b0, 1'b0, "post-reset");
      edge_step();
      drive('0, '0, 1'b0, 1'b0, "post-reset");
      cmp("post-reset head", int'(dat0), 'h5A);
      edge_step();

      // Round-robin rotation with a consumer that keeps up.
      do_reset();
      rr_gnt.delete();
      rr_pop.delete();
      for (int k = 0; k < 6; k++) begin
         drive(3'b111, 24'h332211, 1'b1, 1'b0, "rr");
         edge_step();
      end
      drive('0, '0, 1'b1, 1'b0, "rr");
      edge_step();
      cmp("rr pop count", rr_pop.size(), 6);
      for (int k = 0; k < 6; k++) begin
         cmp($sformatf("rr grant%0d", k), rr_gnt[k], 1 << (k % 3));
         if (k < rr_pop.size()) cmp($sformatf("rr pop_ch%0d", k), rr_pop[k], k % 3);
      end

      // Steady push+pop at count 2 wraps both pointers several times.
      drive(3'b001, 24'h0000A0, 1'b0, 1'b0, "wrap");
      edge_step();
      drive(3'b001, 24'h0000A1, 1'b0, 1'b0, "wrap");
      edge_step();
      fp_pop.delete();
      for (int k = 0; k < 10; k++) begin
         drive(3'b001, 24'(k), 1'b1, 1'b0, "wrap");
         cmp($sformatf("wrap count%0d", k), int'(cnt0), 2);
         edge_step();
      end
      for (int k = 0; k < 2; k++) begin
         drive('0, '0, 1'b1, 1'b0, "wrap");
         edge_step();
      end
      exp_seq = '{'hA0, 'hA1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      cmp("wrap pop count", fp_pop.size(), 12);
      for (int k = 0; k < 12; k++) begin
         if (k < fp_pop.size()) cmp($sformatf("wrap pop%0d", k), fp_pop[k], exp_seq[k]);
      end

      // Random traffic with alternating slow and fast consumer phases.
      for (int n = 0; n < 400; n++) begin
         rd = {8'($urandom), 8'($urandom), 8'($urandom)};
         if (((n / 40) % 2) == 0) rr = ($urandom_range(0, 3) == 0);
         else                     rr = ($urandom_range(0, 3) != 0);
         drive(3'($urandom_range(0, 7)), rd, rr,
               ($urandom_range(0, 15) == 0), "rand");
         edge_step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
